// File: rtl/ir_nec_pkg.sv
// Shared NEC infrared timing constants and types, common to the encoder and
// receiver so both ends of the link agree on every phase length.
package ir_nec_pkg;

  // Default timings in 25 MHz system clock cycles.
  localparam int NEC_T_UNIT       = 14063;    // 562.5 us
  localparam int NEC_LEADER_MARK  = 225000;   // 9 ms
  localparam int NEC_LEADER_SPACE = 112500;   // 4.5 ms
  localparam int NEC_REPEAT_SPACE = 56250;    // 2.25 ms
  localparam int NEC_ONE_SPACE    = 42188;    // 1.6875 ms
  localparam int NEC_ZERO_SPACE   = 14063;    // 562.5 us
  localparam int NEC_GAP          = 1000000;  // 40 ms
  localparam int NEC_CARRIER_DIV  = 658;      // ~38 kHz
  localparam int NEC_CARRIER_HIGH = 329;
  localparam int NEC_CNT_W        = 21;

  // The phase counter must reach the longest phase, which is the larger of
  // the leader mark and the gap.
  function automatic int cnt_w_for(input int leader_mark, input int gap);
    return $clog2(((leader_mark > gap) ? leader_mark : gap) + 1);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_REP_SPACE  = 3'd3,
    ST_BIT_MARK   = 3'd4,
    ST_BIT_SPACE  = 3'd5,
    ST_STOP_MARK  = 3'd6,
    ST_GAP        = 3'd7
  } nec_state_e;

  typedef enum logic {
    FRAME_FULL   = 1'b0,
    FRAME_REPEAT = 1'b1
  } frame_type_e;

endpackage

// File: rtl/ir_carrier_gen.sv
// 38 kHz carrier for the IR LED; restarts on every mark so each burst opens
// with a full high phase, and stays low outside marks.
module ir_carrier_gen
  import ir_nec_pkg::*;
#(
  parameter int CARRIER_DIV  = NEC_CARRIER_DIV,
  parameter int CARRIER_HIGH = NEC_CARRIER_HIGH
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic mark,
  output logic ir_led
);

  localparam int DIV_W = (CARRIER_DIV > 2) ? $clog2(CARRIER_DIV) : 1;

  logic [DIV_W-1:0] carrier_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      carrier_cnt <= '0;
    end else if (enable) begin
      if (!mark || carrier_cnt == DIV_W'(CARRIER_DIV - 1)) begin
        carrier_cnt <= '0;
      end else begin
        carrier_cnt <= carrier_cnt + 1'b1;
      end
    end
  end

  // Counter sits at zero during spaces, so the first mark cycle is high.
  assign ir_led = mark && (int'(carrier_cnt) < CARRIER_HIGH);

endmodule

// File: rtl/ir_nec_encoder.sv
// NEC infrared transmitter: serialises a 32-bit command (LSB first) or a
// repeat code into a pulse-distance frame, baseband and 38 kHz modulated.
module ir_nec_encoder
  import ir_nec_pkg::*;
#(
  parameter int T_UNIT       = NEC_T_UNIT,
  parameter int LEADER_MARK  = NEC_LEADER_MARK,
  parameter int LEADER_SPACE = NEC_LEADER_SPACE,
  parameter int REPEAT_SPACE = NEC_REPEAT_SPACE,
  parameter int ONE_SPACE    = NEC_ONE_SPACE,
  parameter int ZERO_SPACE   = NEC_ZERO_SPACE,
  parameter int GAP          = NEC_GAP,
  parameter int CARRIER_DIV  = NEC_CARRIER_DIV,
  parameter int CARRIER_HIGH = NEC_CARRIER_HIGH,
  parameter int CNT_W        = NEC_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        start,
  input  logic        repeat_req,
  input  logic [31:0] command,
  output logic        busy,
  output logic        done,
  output logic        ir_out,
  output logic        ir_led,
  output logic [3:0]  test
);

  nec_state_e       state, state_next;
  frame_type_e      frame_type;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] phase_len;
  logic             phase_last;
  logic [31:0]      shift_reg;
  logic [4:0]       bit_idx;
  logic             mark;

  // Length of the current phase; a bit space depends on the bit being sent.
  always_comb begin
    phase_len = CNT_W'(1);
    case (state)
      ST_LEAD_MARK:  phase_len = CNT_W'(LEADER_MARK);
      ST_LEAD_SPACE: phase_len = CNT_W'(LEADER_SPACE);
      ST_REP_SPACE:  phase_len = CNT_W'(REPEAT_SPACE);
      ST_BIT_MARK:   phase_len = CNT_W'(T_UNIT);
      ST_BIT_SPACE:  phase_len = shift_reg[0] ? CNT_W'(ONE_SPACE) : CNT_W'(ZERO_SPACE);
      ST_STOP_MARK:  phase_len = CNT_W'(T_UNIT);
      ST_GAP:        phase_len = CNT_W'(GAP);
      default:       phase_len = CNT_W'(1);
    endcase
  end

  assign phase_last = (phase_cnt == phase_len - 1'b1);

  // NOTE: state_next gets its default before the case, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (start || repeat_req) state_next = ST_LEAD_MARK;
      ST_LEAD_MARK:  if (phase_last)
                       state_next = (frame_type == FRAME_FULL) ? ST_LEAD_SPACE : ST_REP_SPACE;
      ST_LEAD_SPACE: if (phase_last) state_next = ST_BIT_MARK;
      ST_REP_SPACE:  if (phase_last) state_next = ST_STOP_MARK;
      ST_BIT_MARK:   if (phase_last) state_next = ST_BIT_SPACE;
      ST_BIT_SPACE:  if (phase_last)
                       state_next = (bit_idx == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
      ST_STOP_MARK:  if (phase_last) state_next = ST_GAP;
      ST_GAP:        if (phase_last) state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      frame_type <= FRAME_FULL;
      phase_cnt  <= '0;
      shift_reg  <= '0;
      bit_idx    <= '0;
      done       <= 1'b0;
    end else if (enable) begin
      state <= state_next;
      done  <= (state == ST_GAP) && phase_last;

      // Every phase exit is a state change, so the counter restarts on entry.
      if (state == ST_IDLE || phase_last) begin
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + 1'b1;
      end

      // Requests are only looked at in IDLE; anything while busy is dropped.
      if (state == ST_IDLE) begin
        if (start) begin
          shift_reg  <= command;
          bit_idx    <= '0;
          frame_type <= FRAME_FULL;
        end else if (repeat_req) begin
          frame_type <= FRAME_REPEAT;
        end
      end

      if (state == ST_BIT_SPACE && phase_last) begin
        shift_reg <= {1'b0, shift_reg[31:1]};
        bit_idx   <= bit_idx + 1'b1;
      end
    end
  end

  assign mark   = (state == ST_LEAD_MARK) || (state == ST_BIT_MARK) || (state == ST_STOP_MARK);
  assign ir_out = !mark;
  assign busy   = (state != ST_IDLE);
  assign test   = {1'b0, state};

  ir_carrier_gen #(
    .CARRIER_DIV  (CARRIER_DIV),
    .CARRIER_HIGH (CARRIER_HIGH)
  ) u_carrier (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .mark   (mark),
    .ir_led (ir_led)
  );

endmodule

// File: tb/tb_ir_nec_encoder.sv
// Bench for ir_nec_encoder with shortened timings: a segment scoreboard on
// ir_out, a carrier model on ir_led and a small NEC decoder for loopback.
module tb_ir_nec_encoder;
  import ir_nec_pkg::*;

  localparam int T_UNIT       = 5;
  localparam int LEADER_MARK  = 20;
  localparam int LEADER_SPACE = 10;
  localparam int REPEAT_SPACE = 7;
  localparam int ONE_SPACE    = 15;
  localparam int ZERO_SPACE   = 5;
  localparam int GAP_LEN      = 30;
  localparam int CARRIER_DIV  = 4;
  localparam int CARRIER_HIGH = 2;
  localparam int CNT_W        = cnt_w_for(LEADER_MARK, GAP_LEN);

  typedef struct {
    logic level;
    int   len;
  } seg_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic        repeat_req = 1'b0;
  logic [31:0] command = '0;
  logic        busy, done, ir_out, ir_led;
  logic [3:0]  test_code;

  int   checks = 0;
  int   errors = 0;
  seg_t exp_q[$];

  // Monitor state
  bit          mon_on = 1'b0;
  bit          led_chk = 1'b1;
  bit          in_frame = 1'b0;
  logic        cur = 1'b1;
  int          run = 0;
  int          hi_idx = 0;
  int          done_cnt = 0;
  logic        done_prev = 1'b0;
  logic [31:0] rx_word = '0;

  always #5 clk = ~clk;

  ir_nec_encoder #(
    .T_UNIT       (T_UNIT),
    .LEADER_MARK  (LEADER_MARK),
    .LEADER_SPACE (LEADER_SPACE),
    .REPEAT_SPACE (REPEAT_SPACE),
    .ONE_SPACE    (ONE_SPACE),
    .ZERO_SPACE   (ZERO_SPACE),
    .GAP          (GAP_LEN),
    .CARRIER_DIV  (CARRIER_DIV),
    .CARRIER_HIGH (CARRIER_HIGH),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .start      (start),
    .repeat_req (repeat_req),
    .command    (command),
    .busy       (busy),
    .done       (done),
    .ir_out     (ir_out),
    .ir_led     (ir_led),
    .test       (test_code)
  );

  // Measures ir_out runs on the falling edge and pops the scoreboard as each
  // run ends; the final gap run ends on the rising edge of done.
  always @(negedge clk) begin
    int   pos;
    logic exp_led;
    bit   seg_end;
    logic seg_lvl;
    int   seg_len;
    seg_t e;
    seg_end = 1'b0;
    seg_lvl = 1'b0;
    seg_len = 0;
    if (rst || !mon_on) begin
      in_frame = 1'b0;
    end else begin
      pos     = (in_frame && cur == 1'b0) ? run : 0;
      exp_led = (ir_out == 1'b0) && ((pos % CARRIER_DIV) < CARRIER_HIGH);
      if (ir_out || led_chk) begin
        checks++;
        if (ir_led !== exp_led) begin
          errors++;
          $display("FAIL carrier at %0t: ir_led=%b expected %b (ir_out=%b pos=%0d)",
                   $time, ir_led, exp_led, ir_out, pos);
        end
      end
      if (done && !done_prev) begin
        done_cnt++;
        if (in_frame) begin
          seg_end  = 1'b1;
          seg_lvl  = cur;
          seg_len  = run;
          in_frame = 1'b0;
        end
      end else if (!in_frame) begin
        if (ir_out == 1'b0) begin
          in_frame = 1'b1;
          cur      = 1'b0;
          run      = 1;
          hi_idx   = 0;
        end
      end else if (ir_out === cur) begin
        run++;
      end else begin
        seg_end = 1'b1;
        seg_lvl = cur;
        seg_len = run;
        if (cur && hi_idx >= 1 && hi_idx <= 32)
          rx_word = {(run > (ONE_SPACE + ZERO_SPACE) / 2), rx_word[31:1]};
        if (cur) hi_idx++;
        cur = ir_out;
        run = 1;
      end
      if (seg_end) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra at %0t: got level %0b len %0d, expected nothing",
                   $time, seg_lvl, seg_len);
        end else begin
          e = exp_q.pop_front();
          if (e.level !== seg_lvl || e.len != seg_len) begin
            errors++;
            $display("FAIL sb_segment at %0t: got level %0b len %0d, expected level %0b len %0d",
                     $time, seg_lvl, seg_len, e.level, e.len);
          end
        end
      end
    end
    done_prev = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seg(input logic level, input int len);
    seg_t s;
    s.level = level;
    s.len   = len;
    exp_q.push_back(s);
  endtask

  // Expected ir_out runs of a full frame; scale=2 models enable at half rate.
  task automatic push_full(input logic [31:0] cmd, input int scale);
    push_seg(1'b0, LEADER_MARK * scale);
    push_seg(1'b1, LEADER_SPACE * scale);
    for (int i = 0; i < 32; i++) begin
      push_seg(1'b0, T_UNIT * scale);
      push_seg(1'b1, (cmd[i] ? ONE_SPACE : ZERO_SPACE) * scale);
    end
    push_seg(1'b0, T_UNIT * scale);
    push_seg(1'b1, GAP_LEN * scale);
  endtask

  task automatic push_repeat();
    push_seg(1'b0, LEADER_MARK);
    push_seg(1'b1, REPEAT_SPACE);
    push_seg(1'b0, T_UNIT);
    push_seg(1'b1, GAP_LEN);
  endtask

  // Waits for done (optionally toggling enable each cycle), checks the idle
  // outputs on the done cycle and that done lasts one enabled cycle.
  task automatic wait_frame(input string name, input int budget, input bit toggle);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      if (toggle && done !== 1'b1) enable = ~enable;
      n++;
    end
    enable = 1'b1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end else begin
      if ({busy, ir_out, ir_led, test_code} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
        errors++;
        $display("FAIL %s_done_state: busy=%b ir_out=%b ir_led=%b test=%0d expected 0 1 0 0",
                 name, busy, ir_out, ir_led, test_code);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL %s_done_width: done=%b expected 0 one cycle later", name, done);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_left: %0d segments outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_accept(input string name, input logic [3:0] exp_code);
    checks++;
    if ({busy, ir_out, ir_led, test_code} !== {1'b1, 1'b0, 1'b1, exp_code}) begin
      errors++;
      $display("FAIL %s_accept: busy=%b ir_out=%b ir_led=%b test=%0d expected 1 0 1 %0d",
               name, busy, ir_out, ir_led, test_code, exp_code);
    end
  endtask

  task automatic test_reset();
    int base;
    mon_on = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    tick();
    checks++;
    if ({ir_out, ir_led, busy, done, test_code} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_idle: ir_out=%b ir_led=%b busy=%b done=%b test=%0d expected 1 0 0 0 0",
               ir_out, ir_led, busy, done, test_code);
    end
    tick();
    tick();
    rst = 1'b0;
    command = 32'h1234_5678;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (LEADER_MARK + LEADER_SPACE + 3 * T_UNIT) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_busy: busy=%b expected 1", busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({ir_out, ir_led, busy, done, test_code} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_mid: ir_out=%b ir_led=%b busy=%b done=%b test=%0d expected 1 0 0 0 0",
               ir_out, ir_led, busy, done, test_code);
    end
    tick();
    tick();
    rst = 1'b0;
    mon_on = 1'b1;
    base = done_cnt;
    repeat (2 * GAP_LEN + 40) tick();
    checks++;
    if (done_cnt != base || busy !== 1'b0 || ir_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_done: done pulses=%0d busy=%b ir_out=%b expected 0 0 1",
               done_cnt - base, busy, ir_out);
    end
  endtask

  task automatic test_full(input string name, input logic [31:0] cmd);
    int base = done_cnt;
    push_full(cmd, 1);
    command = cmd;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_accept(name, 4'd1);
    wait_frame(name, 2000, 1'b0);
    checks++;
    if (done_cnt != base + 1) begin
      errors++;
      $display("FAIL %s_done_count: %0d pulses expected 1", name, done_cnt - base);
    end
  endtask

  task automatic test_repeat();
    int base = done_cnt;
    push_repeat();
    repeat_req = 1'b1;
    tick();
    repeat_req = 1'b0;
    check_accept("repeat", 4'd1);
    wait_frame("repeat", 500, 1'b0);
    checks++;
    if (done_cnt != base + 1) begin
      errors++;
      $display("FAIL repeat_done_count: %0d pulses expected 1", done_cnt - base);
    end
  endtask

  task automatic test_contention();
    int base = done_cnt;
    int n = 0;
    push_full(32'hC0DE_0F0F, 1);
    command = 32'hC0DE_0F0F;
    start = 1'b1;
    repeat_req = 1'b1;
    tick();
    start = 1'b0;
    repeat_req = 1'b0;
    while (test_code !== 4'd5 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (test_code !== 4'd5) begin
      errors++;
      $display("FAIL contention_reach_bit_space: test=%0d expected 5", test_code);
    end
    command = 32'hFFFF_FFFF;
    start = 1'b1;
    repeat_req = 1'b1;
    tick();
    start = 1'b0;
    repeat_req = 1'b0;
    wait_frame("contention", 2000, 1'b0);
    repeat (2 * GAP_LEN) tick();
    checks++;
    if (done_cnt != base + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL contention_no_second: done pulses=%0d busy=%b expected 1 0",
               done_cnt - base, busy);
    end
  endtask

  task automatic test_back_to_back();
    push_full(32'h0000_0001, 1);
    command = 32'h0000_0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_frame("b2b_first", 2000, 1'b0);
    push_repeat();
    repeat_req = 1'b1;
    tick();
    repeat_req = 1'b0;
    check_accept("b2b_second", 4'd1);
    wait_frame("b2b_second", 500, 1'b0);
  endtask

  task automatic test_enable_toggle();
    push_full(32'hA5A5_3C3C, 2);
    led_chk = 1'b0;
    command = 32'hA5A5_3C3C;
    enable = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    enable = 1'b0;
    wait_frame("enable_half", 4000, 1'b1);
    led_chk = 1'b1;
  endtask

  task automatic test_loopback();
    rx_word = '0;
    test_full("loopback", 32'hA5A5_3C3C);
    checks++;
    if (rx_word !== 32'hA5A5_3C3C) begin
      errors++;
      $display("FAIL loopback_decode: got %h expected a5a53c3c", rx_word);
    end
  endtask

  initial begin
    test_reset();
    test_full("full_00ff00ff", 32'h00FF_00FF);
    test_repeat();
    test_contention();
    test_back_to_back();
    test_enable_toggle();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
